one_hot_to_bin_pipe: RTL and testbench

- Downstream companion to the team's binary-to-one-hot encoder: converts a one-hot vector back to a binary index.
- 2-stage valid/ready pipeline, with stall-safe backpressure and malformed-input detection (zero-hot or multi-hot).
- Sits after the encoder and any one-hot routing logic. Its output feeds binary-indexed consumers.
- Closed loop with the encoder (bin -> one-hot -> bin) must return the original index.

---
 rtl/one_hot_pkg.sv | 16 +
 rtl/one_hot_prio_enc.sv | 24 ++
 rtl/one_hot_to_bin_pipe.sv | 119 +++++++++++
 tb/tb_one_hot_to_bin_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/one_hot_pkg.sv
// Shared widths and helpers for the one-hot encode/decode pair.
// The encoder side uses the same constants, so both ends agree on widths.
package one_hot_pkg;

   localparam int unsigned BIN_W     = 4;
   localparam int unsigned ONE_HOT_W = 16;
   localparam int unsigned MAX_W     = 64;

   typedef logic [MAX_W-1:0] wide_t;

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   function automatic logic popcount_gt1(input wide_t v);
      return (v & (v - wide_t'(1))) != '0;
   endfunction

endpackage

// File: rtl/one_hot_prio_enc.sv
// Combinational lowest-set-bit encoder with an all-zero flag.
// Reusable wherever a one-hot (or possibly malformed) vector must become an index.
module one_hot_prio_enc #(
   parameter int unsigned ONE_HOT_W = 16,
   parameter int unsigned BIN_W     = 4
) (
   input  logic [ONE_HOT_W-1:0] one_hot_i,
   output logic [BIN_W-1:0]     bin_o,
   output logic                 zero_o
);

   // Scan from the top down so the lowest set bit is the final assignment.
   always_comb begin
      bin_o  = '0;
      zero_o = 1'b1;
      for (int unsigned i = ONE_HOT_W; i > 0; i--) begin
         if (one_hot_i[i-1]) begin
            bin_o  = BIN_W'(i - 1);
            zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/one_hot_to_bin_pipe.sv
// Two-stage valid/ready one-hot to binary decoder with malformed-word
// detection and a saturating error counter.
module one_hot_to_bin_pipe
   import one_hot_pkg::wide_t;
   import one_hot_pkg::popcount_gt1;
#(
   parameter int unsigned BIN_W     = one_hot_pkg::BIN_W,
   parameter int unsigned ONE_HOT_W = one_hot_pkg::ONE_HOT_W,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ONE_HOT_W-1:0] one_hot_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIN_W-1:0]     bin_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   if (ONE_HOT_W != 2**BIN_W) begin : g_bad_width
      $error("ONE_HOT_W must equal 2**BIN_W");
   end
   if (ONE_HOT_W > one_hot_pkg::MAX_W) begin : g_too_wide
      $error("ONE_HOT_W exceeds one_hot_pkg::MAX_W");
   end

   logic                 s1_valid_q, s1_valid_d;
   logic [ONE_HOT_W-1:0] s1_hot_q,   s1_hot_d;
   logic                 s1_zero_q,  s1_zero_d;
   logic                 s1_multi_q, s1_multi_d;

   logic                 s2_valid_q, s2_valid_d;
   logic [BIN_W-1:0]     s2_bin_q,   s2_bin_d;
   logic                 s2_err_q,   s2_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

   logic                 s2_adv, s1_adv, s1_err;
   logic [BIN_W-1:0]     enc_bin;
   logic                 enc_zero;

   assign s2_adv = ~s2_valid_q | out_ready;
   assign s1_adv = ~s1_valid_q | s2_adv;

   one_hot_prio_enc #(
      .ONE_HOT_W (ONE_HOT_W),
      .BIN_W     (BIN_W)
   ) u_enc (
      .one_hot_i (s1_hot_q),
      .bin_o     (enc_bin),
      .zero_o    (enc_zero)
   );

   // enc_zero duplicates s1_zero_q; folding it in keeps the encoder output live.
   assign s1_err = s1_zero_q | s1_multi_q | enc_zero;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_hot_d   = s1_hot_q;
      s1_zero_d  = s1_zero_q;
      s1_multi_d = s1_multi_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_hot_d   = one_hot_i;
            s1_zero_d  = (one_hot_i == '0);
            s1_multi_d = popcount_gt1(wide_t'(one_hot_i));
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_bin_d   = s2_bin_q;
      s2_err_d   = s2_err_q;
      err_cnt_d  = err_cnt_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_bin_d = enc_bin;
            s2_err_d = s1_err;
            if (s1_err && (err_cnt_q != '1)) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_hot_q   <= '0;
         s1_zero_q  <= 1'b0;
         s1_multi_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_bin_q   <= '0;
         s2_err_q   <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_hot_q   <= s1_hot_d;
         s1_zero_q  <= s1_zero_d;
         s1_multi_q <= s1_multi_d;
         s2_valid_q <= s2_valid_d;
         s2_bin_q   <= s2_bin_d;
         s2_err_q   <= s2_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign bin_o     = s2_bin_q;
   assign err_o     = s2_err_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_one_hot_to_bin_pipe.sv
// Scoreboard bench for one_hot_to_bin_pipe: default instance plus a
// 2-bit error-counter instance for saturation.
module tb_one_hot_to_bin_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, err_o;
   logic [15:0] one_hot_i = '0;
   logic [3:0]  bin_o;
   logic [7:0]  err_cnt_o;

   logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1, err_o2;
   logic [15:0] one_hot_i2 = '0;
   logic [3:0]  bin_o2;
   logic [1:0]  err_cnt_o2;

   one_hot_to_bin_pipe #(.BIN_W(4), .ONE_HOT_W(16), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .one_hot_i(one_hot_i), .out_valid(out_valid), .out_ready(out_ready),
      .bin_o(bin_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
   );

   one_hot_to_bin_pipe #(.BIN_W(4), .ONE_HOT_W(16), .ERR_CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .one_hot_i(one_hot_i2), .out_valid(out_valid2), .out_ready(out_ready2),
      .bin_o(bin_o2), .err_o(err_o2), .err_cnt_o(err_cnt_o2)
   );

   typedef struct {
      logic [3:0]  bin;
      logic        err;
      int unsigned cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        sb2[$];
   int unsigned n_vec = 0, n_err = 0;
   int unsigned mal_cnt = 0, mal_cnt2 = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitors: pop and compare whenever an output transfer happens.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: got bin=%0d err=%0b with no word pending", bin_o, err_o);
         end else begin
            e = sb.pop_front();
            if (bin_o !== e.bin || err_o !== e.err || 32'(err_cnt_o) !== e.cnt) begin
               n_err++;
               $display("FAIL out_word: got bin=%0d err=%0b cnt=%0d expected bin=%0d err=%0b cnt=%0d",
                        bin_o, err_o, err_cnt_o, e.bin, e.err, e.cnt);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid2 && out_ready2) begin
         n_vec++;
         if (sb2.size() == 0) begin
            n_err++;
            $display("FAIL sat_unexpected: got bin=%0d err=%0b with no word pending", bin_o2, err_o2);
         end else begin
            e = sb2.pop_front();
            if (bin_o2 !== e.bin || err_o2 !== e.err || 32'(err_cnt_o2) !== e.cnt) begin
               n_err++;
               $display("FAIL sat_word: got bin=%0d err=%0b cnt=%0d expected bin=%0d err=%0b cnt=%0d",
                        bin_o2, err_o2, err_cnt_o2, e.bin, e.err, e.cnt);
            end
         end
      end
   end

   // Offer one word; expected result pushed once in_ready is seen before the edge.
   task automatic send(input int unsigned sel, input logic [15:0] w, input logic [3:0] b, input logic er);
      int unsigned n;
      exp_t        e;
      if (sel == 0) begin in_valid = 1'b1; one_hot_i = w; end
      else          begin in_valid2 = 1'b1; one_hot_i2 = w; end
      @(negedge clk);
      n = 0;
      while (((sel == 0) ? in_ready : in_ready2) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (((sel == 0) ? in_ready : in_ready2) !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
      end else begin
         e.bin = b;
         e.err = er;
         if (sel == 0) begin
            if (er && mal_cnt < 255) mal_cnt++;
            e.cnt = mal_cnt;
            sb.push_back(e);
         end else begin
            if (er && mal_cnt2 < 3) mal_cnt2++;
            e.cnt = mal_cnt2;
            sb2.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Idle cycles drive garbage on the data bus, which must be ignored.
   task automatic idle(input int unsigned cycles);
      in_valid  = 1'b0; one_hot_i  = 16'hFFFF;
      in_valid2 = 1'b0; one_hot_i2 = 16'hFFFF;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((sb.size() != 0 || sb2.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int unsigned c0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_bin", 32'(bin_o), 0);
      check("rst_err", 32'(err_o), 0);
      check("rst_err_cnt", 32'(err_cnt_o), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;

      // Sweep of single-bit words at full rate
      c0 = cyc;
      for (int unsigned i = 0; i < 16; i++) begin
         send(0, 16'(32'd1 << i), 4'(i), 1'b0);
         if (i == 0) begin
            fork
               begin
                  @(negedge clk);
                  check("lat_not_yet", 32'(out_valid), 0);
                  @(negedge clk);
                  check("lat_first", 32'(out_valid), 1);
               end
            join_none
         end
      end
      check("sweep_throughput_cycles", cyc - c0, 16);
      idle(1);
      drain();

      // Malformed words
      send(0, 16'h0000, 4'd0, 1'b1);
      send(0, 16'h0048, 4'd3, 1'b1);
      send(0, 16'h8001, 4'd0, 1'b1);
      idle(1);
      drain();
      check("malformed_cnt", 32'(err_cnt_o), 3);

      // Backpressure: two words held, then release
      out_ready = 1'b0;
      fork
         begin
            send(0, 16'h0001, 4'd0, 1'b0);
            send(0, 16'h0002, 4'd1, 1'b0);
            send(0, 16'h0004, 4'd2, 1'b0);
            send(0, 16'h0008, 4'd3, 1'b0);
            idle(0);
         end
         begin
            repeat (2) @(posedge clk);
            repeat (4) begin
               @(negedge clk);
               check("stall_in_ready", 32'(in_ready), 0);
               check("stall_out_valid", 32'(out_valid), 1);
               check("stall_bin", 32'(bin_o), 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(1);
      drain();

      // Bubble between two words
      send(0, 16'h0400, 4'd10, 1'b0);
      idle(1);
      send(0, 16'h0010, 4'd4, 1'b0);
      @(negedge clk);
      check("bubble_out_valid", 32'(out_valid), 0);
      idle(1);
      drain();

      // Reset with two words in flight
      out_ready = 1'b0;
      send(0, 16'h0000, 4'd0, 1'b1);
      send(0, 16'h0020, 4'd5, 1'b0);
      reset = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      mal_cnt = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_err_cnt", 32'(err_cnt_o), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      idle(4);
      send(0, 16'h0002, 4'd1, 1'b0);
      idle(1);
      drain();

      // Saturation on the 2-bit counter instance
      for (int unsigned i = 0; i < 5; i++) begin
         send(1, 16'h0000, 4'd0, 1'b1);
      end
      idle(1);
      drain();
      check("sat_final_cnt", 32'(err_cnt_o2), 3);

      idle(3);
      check("sb_empty", sb.size(), 0);
      check("sb2_empty", sb2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
